// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit: funct3 op codes,
// FSM state encodings and the default machine width.
package muldiv_unit_pkg;

    localparam int unsigned MXLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    localparam logic [1:0] MD_IDLE  = 2'd0;
    localparam logic [1:0] MD_CALC  = 2'd1;
    localparam logic [1:0] MD_FIXUP = 2'd2;
    localparam logic [1:0] MD_DONE  = 2'd3;

endpackage

// File: rtl/muldiv_abs.sv
// Two's-complement magnitude helper: when is_signed and the MSB is set the
// value is negated and sign is raised, otherwise the value passes through.
module muldiv_abs
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = MXLEN
) (
    input  logic [XLEN-1:0] value,
    input  logic            is_signed,
    output logic [XLEN-1:0] magnitude,
    output logic            sign
);

    always_comb begin
        sign      = is_signed & value[XLEN-1];
        magnitude = sign ? -value : value;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over a shared
// 2*XLEN accumulator, with valid/ready handshakes and a pass-through tag.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN  = MXLEN,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned CNT_W = $clog2(XLEN + 1);

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q;
    logic [TAG_W-1:0]  tag_q;
    logic              sign_a_q, sign_b_q;
    logic [XLEN-1:0]   mag_b_q, result_q;
    logic [2*XLEN-1:0] acc_q, acc_next;
    logic [CNT_W-1:0]  cnt_q;

    logic              rs1_signed, rs2_signed;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              sign_a, sign_b;
    logic              special;
    logic [XLEN-1:0]   special_result;
    logic              is_mul, last_iter;
    logic [XLEN:0]     add_a, add_b;
    logic [XLEN+1:0]   add_sum;
    logic [2*XLEN-1:0] fix_in;
    logic              fix_neg;
    logic [2*XLEN:0]   fix_mag;
    logic              fix_sign;
    logic [XLEN-1:0]   fix_result;
    logic              unused_fix;

    always_comb begin
        rs1_signed = (in_op == MD_MULH) || (in_op == MD_MULHSU) ||
                     (in_op == MD_DIV)  || (in_op == MD_REM);
        rs2_signed = (in_op == MD_MULH) || (in_op == MD_DIV) || (in_op == MD_REM);
    end

    muldiv_abs #(.XLEN(XLEN)) u_abs_rs1 (
        .value     (in_rs1),
        .is_signed (rs1_signed),
        .magnitude (mag_a),
        .sign      (sign_a)
    );

    muldiv_abs #(.XLEN(XLEN)) u_abs_rs2 (
        .value     (in_rs2),
        .is_signed (rs2_signed),
        .magnitude (mag_b),
        .sign      (sign_b)
    );

    // Divide-by-zero and signed overflow are resolved at accept time.
    always_comb begin
        logic div_zero, overflow;
        div_zero = (in_rs2 == '0);
        overflow = ((in_op == MD_DIV) || (in_op == MD_REM)) &&
                   (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
        special  = in_op[2] && (div_zero || overflow);
        if (div_zero) begin
            special_result = in_op[1] ? in_rs1 : '1;
        end else begin
            special_result = in_op[1] ? '0 : in_rs1;
        end
    end

    // One shared XLEN+1 adder: add for shift-add multiply, subtract for restoring divide.
    always_comb begin
        is_mul  = !op_q[2];
        add_a   = is_mul ? {1'b0, acc_q[2*XLEN-1:XLEN]} : acc_q[2*XLEN-1:XLEN-1];
        add_b   = is_mul ? {1'b0, (acc_q[0] ? mag_b_q : '0)} : ~{1'b0, mag_b_q};
        add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, !is_mul};
        if (is_mul) begin
            acc_next = {add_sum[XLEN:0], acc_q[XLEN-1:1]};
        end else if (add_sum[XLEN+1]) begin
            acc_next = {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {acc_q[2*XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        if (is_mul) begin
            fix_in  = acc_q;
            fix_neg = sign_a_q ^ sign_b_q;
        end else if (!op_q[1]) begin
            fix_in  = {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
            fix_neg = sign_a_q ^ sign_b_q;
        end else begin
            fix_in  = {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]};
            fix_neg = sign_a_q;
        end
    end

    // The negate flag rides in an extra MSB so the magnitude helper negates exactly when asked.
    muldiv_abs #(.XLEN(2*XLEN+1)) u_abs_fix (
        .value     ({fix_neg, fix_in}),
        .is_signed (1'b1),
        .magnitude (fix_mag),
        .sign      (fix_sign)
    );

    assign unused_fix = fix_sign ^ fix_mag[2*XLEN];
    assign fix_result = (is_mul && op_q != MD_MUL) ? fix_mag[2*XLEN-1:XLEN] : fix_mag[XLEN-1:0];
    assign last_iter  = (cnt_q == CNT_W'(XLEN - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE:  if (in_valid) state_d = special ? MD_DONE : MD_CALC;
            MD_CALC:  if (last_iter) state_d = MD_FIXUP;
            MD_FIXUP: state_d = MD_DONE;
            MD_DONE:  if (out_ready) state_d = MD_IDLE;
            default:  state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q  <= MD_IDLE;
            op_q     <= '0;
            tag_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                MD_IDLE: begin
                    if (in_valid) begin
                        op_q     <= in_op;
                        tag_q    <= in_tag;
                        sign_a_q <= sign_a;
                        sign_b_q <= sign_b;
                        mag_b_q  <= mag_b;
                        acc_q    <= {{XLEN{1'b0}}, mag_a};
                        cnt_q    <= '0;
                        if (special) result_q <= special_result;
                    end
                end
                MD_CALC: begin
                    acc_q <= acc_next;
                    if (!last_iter) cnt_q <= cnt_q + CNT_W'(1);
                end
                MD_FIXUP: result_q <= fix_result;
                default: ;
            endcase
        end
    end

    assign in_ready   = (state_q == MD_IDLE);
    assign out_valid  = (state_q == MD_DONE);
    assign out_result = result_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases on an XLEN=32 instance,
// random back-to-back streams on XLEN=32 and XLEN=16 instances.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst, flush;
    always #5 clk = ~clk;

    logic        in_valid [2];
    logic [2:0]  in_op    [2];
    logic [31:0] in_rs1   [2];
    logic [31:0] in_rs2   [2];
    logic [4:0]  in_tag   [2];
    logic        out_ready[2];

    logic        in_ready0, in_ready1, out_valid0, out_valid1;
    logic [31:0] result0;
    logic [15:0] result1;
    logic [4:0]  tag0, tag1;

    logic        rdy [2];
    logic        ov  [2];
    logic [31:0] res [2];
    logic [4:0]  otag[2];

    always_comb begin
        rdy[0] = in_ready0;  rdy[1] = in_ready1;
        ov[0]  = out_valid0; ov[1]  = out_valid1;
        res[0] = result0;    res[1] = {16'h0, result1};
        otag[0] = tag0;      otag[1] = tag1;
    end

    muldiv_unit #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid[0]), .in_ready(in_ready0), .in_op(in_op[0]),
        .in_rs1(in_rs1[0]), .in_rs2(in_rs2[0]), .in_tag(in_tag[0]),
        .out_valid(out_valid0), .out_ready(out_ready[0]),
        .out_result(result0), .out_tag(tag0)
    );

    muldiv_unit #(.XLEN(16), .TAG_W(5)) u_dut16 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid[1]), .in_ready(in_ready1), .in_op(in_op[1]),
        .in_rs1(in_rs1[1][15:0]), .in_rs2(in_rs2[1][15:0]), .in_tag(in_tag[1]),
        .out_valid(out_valid1), .out_ready(out_ready[1]),
        .out_result(result1), .out_tag(tag1)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d required finish", n_checks);
        $fatal(1);
    end

    function automatic logic [31:0] ref_model(input int w, input logic [2:0] op,
                                              input logic [31:0] a_in, input logic [31:0] b_in);
        logic [63:0] mask;
        logic [31:0] a, b;
        longint      ea, eb, p;
        bit          s1, s2;
        mask = (64'd1 << w) - 64'd1;
        a  = 32'(a_in & mask[31:0]);
        b  = 32'(b_in & mask[31:0]);
        s1 = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
        s2 = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
        ea = (s1 && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
        eb = (s2 && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
        p  = ea * eb;
        case (op)
            MD_MUL:                      return 32'(64'(p) & mask);
            MD_MULH, MD_MULHSU, MD_MULHU: return 32'((64'(p) >> w) & mask);
            MD_DIV, MD_DIVU:             return (eb == 0) ? mask[31:0] : 32'(64'(ea / eb) & mask);
            default:                     return (eb == 0) ? a : 32'(64'(ea % eb) & mask);
        endcase
    endfunction

    function automatic bit is_special(input int w, input logic [2:0] op,
                                      input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mask, min_v;
        mask  = 32'((64'd1 << w) - 64'd1);
        min_v = 32'(64'd1 << (w - 1));
        return op[2] && (((b & mask) == 0) ||
               (((op == MD_DIV) || (op == MD_REM)) && ((a & mask) == min_v) && ((b & mask) == mask)));
    endfunction

    task automatic sb_push(input int k, input logic [31:0] r, input logic [4:0] t);
        exp_t e;
        e.result = r;
        e.tag    = t;
        if (k == 0) sb0.push_back(e); else sb1.push_back(e);
    endtask

    task automatic sb_pop(input int k, output exp_t e, output bit ok);
        ok       = (k == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
        e.result = '0;
        e.tag    = '0;
        if (ok) e = (k == 0) ? sb0.pop_front() : sb1.pop_front();
    endtask

    task automatic sb_drop(input int k);
        if (k == 0 && sb0.size() > 0) void'(sb0.pop_back());
        if (k == 1 && sb1.size() > 0) void'(sb1.pop_back());
    endtask

    // Pushes the expectation, presents the request and returns #1 after the accept edge.
    task automatic send(input int k, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] expv);
        int n = 0;
        sb_push(k, expv, tag);
        @(negedge clk);
        in_op[k] = op; in_rs1[k] = a; in_rs2[k] = b; in_tag[k] = tag; in_valid[k] = 1'b1;
        while (!rdy[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[k]) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout dut%0d: in_ready=0 required 1", k);
        end
        @(posedge clk);
        #1 in_valid[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 1;
        while (!ov[k] && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic test_reset();
        n_checks++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", rdy[0]); end
        n_checks++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", ov[0]); end
        n_checks++; if (res[0] !== 32'h0) begin n_fail++; $display("FAIL reset_out_result: got %h required 0", res[0]); end
        n_checks++; if (otag[0] !== 5'h0) begin n_fail++; $display("FAIL reset_out_tag: got %h required 0", otag[0]); end
    endtask

    task automatic test_mul();
        logic [2:0]  ops [4] = '{MD_MULH, MD_MULHU, MD_MULHSU, MD_MUL};
        logic [31:0] av  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
        logic [31:0] bv  [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        logic [31:0] ev  [4] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        exp_t e; bit ok; int lat;
        for (int i = 0; i < 4; i++) begin
            send(0, ops[i], av[i], bv[i], 5'(i + 1), ev[i]);
            wait_valid(0, lat);
            sb_pop(0, e, ok);
            n_checks++; if (!ok || res[0] !== e.result) begin n_fail++; $display("FAIL mul_result[%0d]: got %h required %h", i, res[0], e.result); end
            n_checks++; if (otag[0] !== e.tag) begin n_fail++; $display("FAIL mul_tag[%0d]: got %h required %h", i, otag[0], e.tag); end
            n_checks++; if (lat != 34) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d required 34", i, lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4] = '{MD_DIV, MD_REM, MD_REMU, MD_DIVU};
        logic [31:0] av  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF};
        logic [31:0] bv  [4] = '{32'd2, 32'd2, 32'd2, 32'd2};
        logic [31:0] ev  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF};
        exp_t e; bit ok; int lat;
        for (int i = 0; i < 4; i++) begin
            send(0, ops[i], av[i], bv[i], 5'(i + 8), ev[i]);
            wait_valid(0, lat);
            sb_pop(0, e, ok);
            n_checks++; if (!ok || res[0] !== e.result) begin n_fail++; $display("FAIL div_result[%0d]: got %h required %h", i, res[0], e.result); end
            n_checks++; if (otag[0] !== e.tag) begin n_fail++; $display("FAIL div_tag[%0d]: got %h required %h", i, otag[0], e.tag); end
            n_checks++; if (lat != 34) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d required 34", i, lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [4] = '{MD_DIVU, MD_REMU, MD_DIV, MD_REM};
        logic [31:0] av  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev  [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        exp_t e; bit ok; int lat;
        for (int i = 0; i < 4; i++) begin
            send(0, ops[i], av[i], bv[i], 5'(i + 16), ev[i]);
            wait_valid(0, lat);
            sb_pop(0, e, ok);
            n_checks++; if (!ok || res[0] !== e.result) begin n_fail++; $display("FAIL special_result[%0d]: got %h required %h", i, res[0], e.result); end
            n_checks++; if (otag[0] !== e.tag) begin n_fail++; $display("FAIL special_tag[%0d]: got %h required %h", i, otag[0], e.tag); end
            n_checks++; if (lat != 1) begin n_fail++; $display("FAIL special_latency[%0d]: got %0d required 1", i, lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held_r; logic [4:0] held_t;
        exp_t e; bit ok; int lat, seen;
        out_ready[0] = 1'b0;
        send(0, MD_DIVU, 32'd100, 32'd7, 5'h1A, 32'd14);
        wait_valid(0, lat);
        held_r = res[0];
        held_t = otag[0];
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (res[0] !== held_r || otag[0] !== held_t || rdy[0] !== 1'b0 || ov[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: result=%h tag=%h in_ready=%b out_valid=%b required %h %h 0 1",
                         i, res[0], otag[0], rdy[0], ov[0], held_r, held_t);
            end
        end
        sb_pop(0, e, ok);
        n_checks++; if (!ok || res[0] !== e.result || otag[0] !== e.tag) begin n_fail++; $display("FAIL bp_value: got %h/%h required %h/%h", res[0], otag[0], e.result, e.tag); end
        @(negedge clk) out_ready[0] = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (ov[0] !== 1'b0 || rdy[0] !== 1'b1) begin n_fail++; $display("FAIL bp_transfer: out_valid=%b in_ready=%b required 0 1", ov[0], rdy[0]); end
        seen = 0;
        repeat (5) begin @(posedge clk); #1; if (ov[0]) seen++; end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL bp_single: extra out_valid cycles %0d required 0", seen); end
    endtask

    task automatic test_flush();
        exp_t e; bit ok; int lat, seen;
        send(0, MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h05, 32'hFFFF_FFFE);
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (rdy[0] !== 1'b1 || ov[0] !== 1'b0) begin n_fail++; $display("FAIL flush_calc: in_ready=%b out_valid=%b required 1 0", rdy[0], ov[0]); end
        sb_drop(0);
        // Flush must win over an accept presented in the same cycle.
        @(negedge clk);
        in_op[0] = MD_MUL; in_rs1[0] = 32'd5; in_rs2[0] = 32'd5; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL flush_vs_accept: in_ready=%b required 1", rdy[0]); end
        @(negedge clk) begin flush = 1'b0; in_valid[0] = 1'b0; end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (ov[0]) seen++; end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_stale: out_valid cycles %0d required 0", seen); end
        send(0, MD_MUL, 32'd3, 32'd4, 5'h06, 32'd12);
        wait_valid(0, lat);
        sb_pop(0, e, ok);
        n_checks++; if (!ok || res[0] !== e.result) begin n_fail++; $display("FAIL flush_after_mul: got %h required %h", res[0], e.result); end
        n_checks++; if (lat != 34) begin n_fail++; $display("FAIL flush_after_latency: got %0d required 34", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        send(0, MD_MULH, 32'h8000_0000, 32'h8000_0000, 5'h0F, 32'h4000_0000);
        repeat (32) @(posedge clk);
        @(negedge clk);
        n_checks++; if (rdy[0] !== 1'b0 || ov[0] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: in_ready=%b out_valid=%b required 0 0", rdy[0], ov[0]); end
        rst = 1'b1;
        @(posedge clk); #1;
        sb_drop(0);
        test_reset();
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (ov[0]) seen++; end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_mid_stale: out_valid cycles %0d required 0", seen); end
    endtask

    task automatic test_back_to_back(input int k, input int n);
        int w = (k == 0) ? 32 : 16;
        out_ready[k] = 1'b1;
        fork
            begin : driver
                int prev_t = 0;
                bit prev_sp = 1'b0;
                for (int i = 0; i < n; i++) begin
                    logic [2:0]  op;
                    logic [31:0] a, b, mask;
                    int wait_n = 0;
                    mask = 32'((64'd1 << w) - 64'd1);
                    op = 3'($urandom_range(0, 7));
                    a  = $urandom & mask;
                    b  = (i % 6 == 5) ? 32'd0 : ($urandom & mask);
                    if (i == 7) begin op = MD_DIV; a = 32'(64'd1 << (w - 1)); b = mask; end
                    sb_push(k, ref_model(w, op, a, b), 5'(i));
                    @(negedge clk);
                    in_op[k] = op; in_rs1[k] = a; in_rs2[k] = b; in_tag[k] = 5'(i); in_valid[k] = 1'b1;
                    while (!rdy[k] && wait_n < 200) begin @(negedge clk); wait_n++; end
                    @(posedge clk); #1;
                    if (i > 0) begin
                        n_checks++;
                        if (cyc - prev_t != (prev_sp ? 2 : w + 3)) begin
                            n_fail++;
                            $display("FAIL b2b_gap dut%0d[%0d]: got %0d required %0d", k, i, cyc - prev_t, prev_sp ? 2 : w + 3);
                        end
                    end
                    prev_t  = cyc;
                    prev_sp = is_special(w, op, a, b);
                end
                @(negedge clk) in_valid[k] = 1'b0;
            end
            begin : monitor
                int got = 0, spent = 0;
                exp_t e; bit ok;
                while (got < n && spent < n * (w + 6) + 200) begin
                    @(negedge clk);
                    spent++;
                    if (ov[k]) begin
                        sb_pop(k, e, ok);
                        n_checks++;
                        if (!ok || res[k] !== e.result || otag[k] !== e.tag) begin
                            n_fail++;
                            $display("FAIL b2b_result dut%0d[%0d]: got %h/%h required %h/%h", k, got, res[k], otag[k], e.result, e.tag);
                        end
                        got++;
                    end
                end
                if (got < n) begin
                    n_checks++; n_fail++;
                    $display("FAIL b2b_timeout dut%0d: results %0d required %0d", k, got, n);
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_op[k] = '0; in_rs1[k] = '0; in_rs2[k] = '0;
            in_tag[k] = '0; out_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk) rst = 1'b0;
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_back_to_back(0, 16);
        test_back_to_back(1, 16);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit. Successor to the combinational ALU's M-extension ops: parametrised width, a valid/ready handshake on both sides, a transaction tag, and exact RISC-V corner-case results. It sits beside the ALU in the execute stage; the pipeline stalls on `in_ready`/`out_valid`.

## Interface
- `XLEN`, default `MXLEN`: operand and result width; must be ≥ 8 and even.
- `TAG_W`, default 5: width of the opaque tag, normally the rd index.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: one clock; reset is synchronous and active-high.
- `flush` input 1: abort the in-flight operation; same effect as `rst` on state.
- `in_valid` input 1: request valid.
- `in_ready` output 1: unit can accept a request.
- `in_op` input 3: RISC-V funct3. MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- `in_rs1`, `in_rs2` input XLEN: operands.
- `in_tag` input TAG_W: returned unchanged with the result.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_result` output XLEN: result.
- `out_tag` output TAG_W: tag of the result.

## Operation
- **Handshakes.** Accept happens when `in_valid && in_ready`. Result transfer happens when `out_valid && out_ready`.
- **FSM states.**
  - IDLE: `in_ready`=1. On accept, go to CALC. If the op is a special-case division, go straight to DONE.
  - CALC: runs exactly XLEN iterations, one bit per cycle, then goes to FIXUP.
  - FIXUP: applies sign correction and result selection, then goes to DONE.
  - DONE: `out_valid`=1. On transfer, go to IDLE.
- **Accept cycle.**
  - Latch op and tag.
  - Convert each operand to magnitude plus sign. rs1 is signed for MULH, MULHSU, DIV and REM. rs2 is signed for MULH, DIV and REM. Otherwise operands are unsigned.
- **Multiply.**
  - Shift-add on magnitudes into a 2·XLEN accumulator.
  - FIXUP negates the product when the two signs differ.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- **Divide.**
  - Restoring shift-subtract on magnitudes.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- **Special cases** (detected in IDLE, bypass CALC):
  - Divide by zero: quotient is all ones; remainder is rs1.
  - Signed overflow (rs1 = −2^(XLEN−1), rs2 = −1, DIV/REM only): quotient is rs1; remainder is 0.
- `out_result` and `out_tag` are held stable while `out_valid && !out_ready`.
- `flush` or `rst`:
  - FSM goes to IDLE, `out_valid`=0, and the in-flight result is discarded.
  - A request presented in the same cycle is not accepted.
  - `flush` has priority over accept and over transfer.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_result`=0, `out_tag`=0. Iteration counter and accumulators are cleared.
- Normal latency: `out_valid` rises XLEN+2 cycles after the accept edge (XLEN cycles in CALC, 1 in FIXUP, then registered into DONE). For XLEN=32 this is 34 cycles.
- Special-case latency: `out_valid` rises 1 cycle after accept.
- `in_ready` is a pure function of state (IDLE only). There is no combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`.
- Throughput: one op per XLEN+3 cycles when `out_ready` is held high. There is no accept in the transfer cycle; IDLE is re-entered on the next edge.
- Iteration counter is ⌈log2(XLEN+1)⌉ bits. It counts 0..XLEN−1 and then exits; it never wraps.
- Ops are fixed at accept; operand or op changes on the input during CALC have no effect.

## Structure
- `defs.v` gains:
  - the funct3 constants `MD_MUL` … `MD_REMU`;
  - the state encodings `MD_IDLE`, `MD_CALC`, `MD_FIXUP`, `MD_DONE`;
  - `MXLEN` (existing) is reused.
- One sub-module, `muldiv_abs`: XLEN-parametrised two's-complement magnitude/negate helper, with inputs value and is_signed and outputs magnitude and sign. It is instantiated for rs1 and rs2 and reused for final negation.
- The multiply and divide datapaths share one 2·XLEN accumulator and one XLEN adder/subtractor.

## Test plan
- **MULH:** 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MUL 7 × −3 → 0xFFFFFFEB. Each `out_valid` arrives exactly 34 cycles after accept.
- **Signed divide:** DIV −7/2 → 0xFFFFFFFD; REM −7%2 → 0xFFFFFFFF; REMU 7%2 → 1; DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF.
- **Special cases:** DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0. Each `out_valid` arrives 1 cycle after accept.
- **Backpressure:** hold `out_ready`=0 for 5 cycles with tag 0x1A. `out_result`/`out_tag` stay stable, `in_ready` stays 0, and a single transfer occurs.
- **Flush:** assert `flush` at CALC cycle 10. Next cycle `in_ready`=1 and `out_valid`=0, and no stale result appears. A following MUL 3×4 returns 12.
- **Reset mid-operation:** assert `rst` in FIXUP. All outputs take their reset values. Back-to-back ops with random operands, compared against a reference model for XLEN=32 and XLEN=16.
